axis_fifo_pkt: RTL



---
 rtl/axis_fifo_pkg.sv | 19 +
 rtl/axis_fifo_ram.sv | 29 ++
 rtl/axis_fifo_pkt.sv | 115 +++++++++++
 3 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared defaults and elaboration helpers for the AXI4-Stream packet FIFO.
package axis_fifo_pkg;

    localparam int DEF_DATA_W    = 64;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_AFULL_TH  = 48;
    localparam int DEF_AEMPTY_TH = 1;

    // Occupancy runs 0..2^addr_w inclusive, so it needs one extra bit.
    function automatic int count_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic bit th_ok(input int addr_w, input int afull, input int aempty);
        return (afull >= 1) && (afull <= (1 << addr_w)) &&
               (aempty >= 0) && (aempty <= (1 << addr_w) - 1);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port {tlast, tdata} store: synchronous write, registered read
// with write-through so a word written to the read address lands in one clock.
module axis_fifo_ram import axis_fifo_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W:0]   wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W:0]   rdata
);

    logic [DATA_W:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the read register is reset; it doubles as the FWFT output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/axis_fifo_pkt.sv
// AXI4-Stream FWFT FIFO with occupancy flags and optional store-and-forward
// packet mode; the RAM read register always holds the word at the read pointer.
module axis_fifo_pkt import axis_fifo_pkg::*; #(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int AFULL_TH    = DEF_AFULL_TH,
    parameter int AEMPTY_TH   = DEF_AEMPTY_TH,
    parameter int PACKET_MODE = 0
) (
    input  logic              fifo_clk,
    input  logic              fifo_rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty
);

    localparam int CW    = count_w(ADDR_W);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CW-1:0] FULL_C = DEPTH[CW-1:0];
    localparam logic [CW-1:0] AF_C   = AFULL_TH[CW-1:0];
    localparam logic [CW-1:0] AE_C   = AEMPTY_TH[CW-1:0];

    if (!th_ok(ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_bad_th
        $error("axis_fifo_pkt: AFULL_TH/AEMPTY_TH out of range for ADDR_W");
    end

    logic [ADDR_W-1:0] wptr, rptr, rptr_nxt;
    logic [CW-1:0]     count;
    logic              head_valid, push, pop, rd_en;
    logic [DATA_W:0]   head;

    assign head_valid = (count != '0);
    assign s_tready   = !fifo_full;
    assign push       = s_tvalid & s_tready;
    assign pop        = m_tvalid & m_tready;
    assign rptr_nxt   = pop ? rptr + 1'b1 : rptr;
    // Refresh the head on a pop, or when a push lands in an empty FIFO.
    assign rd_en      = pop | (push & ~head_valid);

    always_ff @(posedge fifo_clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    axis_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (fifo_clk),
        .rst   (fifo_rst),
        .we    (push),
        .waddr (wptr),
        .wdata ({s_tlast, s_tdata}),
        .re    (rd_en),
        .raddr (rptr_nxt),
        .rdata (head)
    );

    assign m_tdata           = head[DATA_W-1:0];
    assign m_tlast           = head[DATA_W];
    assign fifo_count        = count;
    assign fifo_full         = (count == FULL_C);
    assign fifo_empty        = (count == '0);
    assign fifo_almost_full  = (count >= AF_C);
    assign fifo_almost_empty = (count <= AE_C);

    if (PACKET_MODE != 0) begin : g_pkt
        logic [CW-1:0] pkt_cnt;
        logic          rel;
        logic          pkt_in, pkt_out;

        assign pkt_in  = push & s_tlast;
        assign pkt_out = pop & m_tlast;

        always_ff @(posedge fifo_clk or posedge fifo_rst) begin
            if (fifo_rst) begin
                pkt_cnt <= '0;
                rel     <= 1'b0;
            end else begin
                case ({pkt_in, pkt_out})
                    2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                    2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                    default: pkt_cnt <= pkt_cnt;
                endcase
                // A full FIFO with no complete packet can only be a packet
                // larger than the FIFO: fall back to cut-through until its end.
                if (fifo_full && pkt_cnt == '0) rel <= 1'b1;
                else if (pkt_out)               rel <= 1'b0;
            end
        end

        assign m_tvalid = head_valid & ((pkt_cnt != '0) | rel);
    end else begin : g_cut
        assign m_tvalid = head_valid;
    end

endmodule
